// File: rtl/test_monitor.sv
// ============================================================================
// Module      : test_monitor
// Description : Watches core write-back/retire traffic and reports riscv-tests
//               pass / fail / timeout verdicts with cycle and retire counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module test_monitor #(
  parameter logic [31:0] TIMEOUT = 32'd5000,
  parameter logic [4:0]  GP_ADDR = 5'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        retire,
  input  logic        ecall,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [30:0] test_num,
  output logic [31:0] cycle_count,
  output logic [31:0] retire_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TMO  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] gp_q, gp_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] retire_count_q, retire_count_d;
  logic [30:0] test_num_q, test_num_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        timeout_q, timeout_d;

  logic        gp_wr;
  logic [31:0] g_eff;
  logic        verdict;
  logic [31:0] cycle_inc;
  logic [31:0] retire_inc;

  always_comb begin
    // Register x0 is hardwired, so a GP_ADDR of 0 never loads the shadow.
    gp_wr      = wb_en && (wb_addr == GP_ADDR) && (wb_addr != 5'd0);
    gp_d       = gp_wr ? wb_data : gp_q;
    g_eff      = gp_wr ? wb_data : gp_q;
    verdict    = retire && ecall && g_eff[0];
    cycle_inc  = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q : cycle_count_q + 32'd1;
    retire_inc = (retire_count_q == 32'hFFFF_FFFF) ? retire_count_q : retire_count_q + 32'd1;

    state_d        = state_q;
    cycle_count_d  = cycle_count_q;
    retire_count_d = retire_count_q;
    test_num_d     = test_num_q;

    if (clear) begin
      state_d        = ST_IDLE;
      cycle_count_d  = 32'd0;
      retire_count_d = 32'd0;
      test_num_d     = 31'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (retire) begin
            state_d        = ST_RUN;
            cycle_count_d  = 32'd1;
            retire_count_d = 32'd1;
          end
        end
        ST_RUN: begin
          if (retire) retire_count_d = retire_inc;
          // A verdict ECALL on the last allowed cycle beats the timeout.
          if (verdict) begin
            cycle_count_d = cycle_inc;
            if (g_eff == 32'd1) begin
              state_d = ST_PASS;
            end else begin
              state_d    = ST_FAIL;
              test_num_d = g_eff[31:1];
            end
          end else if (cycle_count_q == (TIMEOUT - 32'd1)) begin
            state_d = ST_TMO;
          end else begin
            cycle_count_d = cycle_inc;
          end
        end
        default: ;
      endcase
    end

    done_d    = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TMO);
    pass_d    = (state_d == ST_PASS);
    fail_d    = (state_d == ST_FAIL);
    timeout_d = (state_d == ST_TMO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      gp_q           <= 32'd0;
      cycle_count_q  <= 32'd0;
      retire_count_q <= 32'd0;
      test_num_q     <= 31'd0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      gp_q           <= gp_d;
      cycle_count_q  <= cycle_count_d;
      retire_count_q <= retire_count_d;
      test_num_q     <= test_num_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      timeout_q      <= timeout_d;
    end
  end

  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign test_num     = test_num_q;
  assign cycle_count  = cycle_count_q;
  assign retire_count = retire_count_q;

endmodule

`default_nettype wire

// File: tb/tb_test_monitor.sv
// ============================================================================
// Module      : tb_test_monitor
// Description : Self-checking bench for test_monitor: vector table, directed
//               corner sequences and randomized traffic against a model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_test_monitor;

  localparam logic [31:0] TMO_CYC = 32'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        retire = 1'b0;
  logic        ecall = 1'b0;
  logic        done, pass, fail, timeout;
  logic [30:0] test_num;
  logic [31:0] cycle_count, retire_count;

  int checks = 0;
  int errors = 0;

  test_monitor #(.TIMEOUT(TMO_CYC), .GP_ADDR(5'd3)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .retire(retire), .ecall(ecall), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .test_num(test_num),
    .cycle_count(cycle_count), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // Reference model: started flag, verdict code (0 none, 1 pass, 2 fail, 3 tmo)
  bit          m_started;
  int          m_res;
  logic [31:0] m_gp, m_cc, m_rc;
  logic [30:0] m_tn;

  function automatic logic [98:0] mk(logic [3:0] f, logic [30:0] tn, logic [31:0] cc, logic [31:0] rc);
    return {f, tn, cc, rc};
  endfunction

  function automatic logic [98:0] outs();
    return {done, pass, fail, timeout, test_num, cycle_count, retire_count};
  endfunction

  function automatic logic [98:0] model_outs();
    logic [3:0] f;
    f = {m_res != 0, m_res == 1, m_res == 2, m_res == 3};
    return mk(f, m_tn, m_cc, m_rc);
  endfunction

  task automatic chk(string name, logic [98:0] act, logic [98:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_res = 0; m_gp = 0; m_cc = 0; m_rc = 0; m_tn = 0;
  endtask

  // One rising edge seen from the test program's point of view.
  task automatic model_edge();
    logic [31:0] g;
    bit wr;
    wr = wb_en && (wb_addr == 5'd3);
    g  = wr ? wb_data : m_gp;
    if (wr) m_gp = wb_data;
    if (clear) begin
      m_started = 0; m_res = 0; m_cc = 0; m_rc = 0; m_tn = 0;
    end else if (m_res != 0) begin
      // finished: nothing but the gp shadow moves
    end else if (!m_started) begin
      if (retire) begin m_started = 1; m_cc = 1; m_rc = 1; end
    end else begin
      if (retire && m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
      if (retire && ecall && g == 32'd1) begin
        m_res = 1; m_cc = m_cc + 1;
      end else if (retire && ecall && g[0]) begin
        m_res = 2; m_tn = g[31:1]; m_cc = m_cc + 1;
      end else if (m_cc == TMO_CYC - 1) begin
        m_res = 3;
      end else if (m_cc != 32'hFFFF_FFFF) begin
        m_cc = m_cc + 1;
      end
    end
  endtask

  task automatic step(bit c, bit we, logic [4:0] a, logic [31:0] d, bit r, bit e);
    clear = c; wb_en = we; wb_addr = a; wb_data = d; retire = r; ecall = e;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'd0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 0; clear = 0; wb_en = 0; wb_addr = 0; wb_data = 0; retire = 0; ecall = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  // Async reset issued mid-cycle: outputs must drop before the next edge.
  task automatic async_reset(string name);
    clear = 0; wb_en = 0; retire = 0; ecall = 0;
    #1 rst = 0;
    #1 chk(name, outs(), mk(4'b0000, 31'd0, 32'd0, 32'd0));
    model_reset();
    @(posedge clk);
    #1 rst = 1;
  endtask

  typedef struct packed {
    logic        clr;
    logic        wbe;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ret;
    logic        ec;
    logic [3:0]  f;
    logic [30:0] tn;
    logic [31:0] cc;
    logic [31:0] rc;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // {clr, wbe, addr, data, ret, ec, {done,pass,fail,tmo}, test_num, cycles, retires}
    tbl[0]  = '{1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 4'b0000, 31'd0, 32'd0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 5'd5, 32'd7,  1'b0, 1'b0, 4'b0000, 31'd0, 32'd0, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 5'd0, 32'd1,  1'b0, 1'b0, 4'b0000, 31'd0, 32'd0, 32'd0};
    tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 4'b0000, 31'd0, 32'd1, 32'd1};
    tbl[4]  = '{1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 4'b0000, 31'd0, 32'd2, 32'd1};
    tbl[5]  = '{1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b1, 4'b0000, 31'd0, 32'd3, 32'd2};
    tbl[6]  = '{1'b0, 1'b1, 5'd3, 32'd1,  1'b0, 1'b1, 4'b0000, 31'd0, 32'd4, 32'd2};
    tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b1, 4'b1100, 31'd0, 32'd5, 32'd3};
    tbl[8]  = '{1'b0, 1'b1, 5'd3, 32'hB,  1'b1, 1'b0, 4'b1100, 31'd0, 32'd5, 32'd3};
    tbl[9]  = '{1'b1, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 4'b0000, 31'd0, 32'd0, 32'd0};
    tbl[10] = '{1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b1, 4'b0000, 31'd0, 32'd1, 32'd1};
    tbl[11] = '{1'b0, 1'b0, 5'd0, 32'd0,  1'b1, 1'b1, 4'b1010, 31'd5, 32'd2, 32'd2};
    tbl[12] = '{1'b0, 1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 4'b1010, 31'd5, 32'd2, 32'd2};

    do_reset();
    chk("reset_state", outs(), mk(4'b0000, 31'd0, 32'd0, 32'd0));

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].clr, tbl[i].wbe, tbl[i].addr, tbl[i].data, tbl[i].ret, tbl[i].ec);
      chk($sformatf("vec%0d", i), outs(), mk(tbl[i].f, tbl[i].tn, tbl[i].cc, tbl[i].rc));
    end

    // Pass: first retire loads gp=1, ecall ten cycles later
    do_reset();
    step(0, 1, 5'd3, 32'd1, 1, 0);
    idle(9);
    step(0, 0, 5'd0, 32'd0, 1, 1);
    chk("pass_basic", outs(), mk(4'b1100, 31'd0, 32'd11, 32'd2));

    // Fail: gp=0xB reports test 5
    do_reset();
    step(0, 0, 5'd0, 32'd0, 1, 0);
    step(0, 1, 5'd3, 32'hB, 0, 0);
    step(0, 0, 5'd0, 32'd0, 1, 1);
    chk("fail_basic", outs(), mk(4'b1010, 31'd5, 32'd3, 32'd2));

    // Same-cycle write of gp is seen by the ecall
    do_reset();
    step(0, 0, 5'd0, 32'd0, 1, 0);
    step(0, 1, 5'd3, 32'd1, 1, 1);
    chk("bypass", outs(), mk(4'b1100, 31'd0, 32'd2, 32'd2));

    // Timeout lands one edge after cycle_count reaches 99, then freezes
    do_reset();
    step(0, 0, 5'd0, 32'd0, 1, 0);
    idle(98);
    chk("tmo_edge_minus1", outs(), mk(4'b0000, 31'd0, 32'd99, 32'd1));
    idle(1);
    chk("tmo_hit", outs(), mk(4'b1001, 31'd0, 32'd99, 32'd1));
    step(0, 1, 5'd3, 32'd1, 1, 1);
    idle(2);
    chk("tmo_frozen", outs(), mk(4'b1001, 31'd0, 32'd99, 32'd1));

    // Verdict on the timeout cycle wins
    do_reset();
    step(0, 1, 5'd3, 32'd1, 0, 0);
    step(0, 0, 5'd0, 32'd0, 1, 0);
    idle(98);
    chk("race_pre", outs(), mk(4'b0000, 31'd0, 32'd99, 32'd1));
    step(0, 0, 5'd0, 32'd0, 1, 1);
    chk("race_pass_wins", outs(), mk(4'b1100, 31'd0, 32'd100, 32'd2));

    // Even gp is ignored, later gp=1 passes
    do_reset();
    step(0, 0, 5'd0, 32'd0, 1, 0);
    step(0, 1, 5'd3, 32'd4, 0, 0);
    step(0, 0, 5'd0, 32'd0, 1, 1);
    chk("even_gp", outs(), mk(4'b0000, 31'd0, 32'd3, 32'd2));
    step(0, 1, 5'd3, 32'd1, 0, 0);
    step(0, 0, 5'd0, 32'd0, 1, 1);
    chk("even_then_pass", outs(), mk(4'b1100, 31'd0, 32'd5, 32'd3));

    // Async reset mid-RUN, then in PASS
    do_reset();
    step(0, 0, 5'd0, 32'd0, 1, 0);
    idle(3);
    async_reset("async_rst_run");
    step(0, 1, 5'd3, 32'd1, 1, 0);
    step(0, 0, 5'd0, 32'd0, 1, 1);
    chk("pass_before_rst", outs(), mk(4'b1100, 31'd0, 32'd2, 32'd2));
    async_reset("async_rst_pass");

    // Clear out of PASS keeps gp so the next test passes at once
    step(0, 1, 5'd3, 32'd1, 1, 0);
    step(0, 0, 5'd0, 32'd0, 1, 1);
    step(1, 0, 5'd0, 32'd0, 1, 1);
    chk("clear_in_pass", outs(), mk(4'b0000, 31'd0, 32'd0, 32'd0));
    step(0, 0, 5'd0, 32'd0, 1, 0);
    step(0, 0, 5'd0, 32'd0, 1, 1);
    chk("pass_after_clear", outs(), mk(4'b1100, 31'd0, 32'd2, 32'd2));

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bit          c, we, r, e;
      logic [4:0]  a;
      logic [31:0] d;
      if ($urandom_range(0, 999) < 3) begin
        async_reset("rand_async_rst");
        continue;
      end
      c  = ($urandom_range(0, 99) < 2);
      we = !c && ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 3))
        0:       a = 5'd0;
        1, 2:    a = 5'd3;
        default: a = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 5))
        0:       d = 32'd0;
        1:       d = 32'd1;
        2:       d = 32'd2;
        3:       d = 32'd4;
        4:       d = 32'hB;
        default: d = $urandom;
      endcase
      r = ($urandom_range(0, 1) == 1);
      e = ($urandom_range(0, 9) < 2);
      step(c, we, a, d, r, e);
      chk($sformatf("rand%0d", n), outs(), model_outs());
      chk($sformatf("rand%0d_onehot", n), 99'(32'(pass) + 32'(fail) + 32'(timeout) <= 1), 99'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
